// File: rtl/controle_pkg.sv
// Shared types for the multi-cycle nRisc control unit: FSM states, opcodes
// and datapath select encodings.
package controle_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam logic [2:0] OP_LW   = 3'b000;
  localparam logic [2:0] OP_SW   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ADDI = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'b00,
    PC_INC    = 2'b01,
    PC_BRANCH = 2'b10,
    PC_JUMP   = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    RW_NONE = 2'b00,
    RW_ULA  = 2'b01,
    RW_MEM  = 2'b10
  } reg_wr_e;

  typedef enum logic [1:0] {
    ULA_ADD   = 2'b00,
    ULA_SUB   = 2'b01,
    ULA_SLT   = 2'b10,
    ULA_PASSB = 2'b11
  } ula_op_e;

  function automatic logic is_mem_op(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/contador_timeout.sv
// Watchdog counter: counts enabled cycles, saturates at LIMIT and flags expiry.
// LIMIT of 0 disables the watchdog entirely.
module contador_timeout #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         hit;

  assign hit       = (LIMIT != 0) && (cnt_q == W'(LIMIT));
  assign expired_o = hit;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !hit && (LIMIT != 0)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multi-cycle nRisc control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a
// memory-ready watchdog, illegal-opcode trap and retired-instruction counter.
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 3,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opCode,
  input  logic                mem_ready,
  input  logic                zero,
  output logic [1:0]          PCWrite,
  output logic [1:0]          RegWrite,
  output logic [1:0]          UlaOp,
  output logic                IRWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                UlaSrc,
  output logic                RegSrc,
  output logic                Jump,
  output logic                beq,
  output logic                halted,
  output logic                illegal,
  output logic                timeout,
  output logic [CNT_W-1:0]    instr_count,
  output logic [2:0]          state
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic             retire;

  logic             wd_en, wd_clr, wd_expired;

  logic [7:0]       opc_ext;
  logic             opc_illegal;
  logic [2:0]       opc_lo;

  pc_sel_e          pc_w;
  reg_wr_e          rw;
  ula_op_e          ula_op;
  logic             ir_w, mem_rd, mem_wr, ula_src, reg_src, jump_s, beq_s;

  assign opc_ext     = 8'(opCode);
  assign opc_illegal = |opc_ext[7:3];
  assign opc_lo      = opc_ext[2:0];

  assign wd_en  = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
  assign wd_clr = (state_d != state_q);

  contador_timeout #(
    .LIMIT(MEM_TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (reset),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expired_o(wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    retire    = 1'b0;
    pc_w      = PC_HOLD;
    rw        = RW_NONE;
    ula_op    = ULA_ADD;
    ir_w      = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    ula_src   = 1'b0;
    reg_src   = 1'b0;
    jump_s    = 1'b0;
    beq_s     = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_rd = 1'b1;
        // Expiry wins over a mem_ready arriving in the same cycle.
        if (wd_expired) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end else if (mem_ready) begin
          ir_w    = 1'b1;
          pc_w    = PC_INC;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        // op_q is not valid yet here, so decode uses the live opcode.
        op_d = opc_lo;
        if (opc_illegal) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else if (opc_lo == OP_HALT) begin
          state_d = S_HALT;
        end else if (opc_lo == OP_JMP) begin
          jump_s  = 1'b1;
          pc_w    = PC_JUMP;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (is_mem_op(op_q)) begin
          ula_op  = ULA_ADD;
          ula_src = 1'b1;
          state_d = S_MEM;
        end else begin
          case (op_q)
            OP_ADD: begin
              ula_op  = ULA_ADD;
              state_d = S_WB;
            end
            OP_ADDI: begin
              ula_op  = ULA_ADD;
              ula_src = 1'b1;
              state_d = S_WB;
            end
            OP_SLT: begin
              ula_op  = ULA_SLT;
              state_d = S_WB;
            end
            OP_BEQ: begin
              ula_op  = ULA_SUB;
              beq_s   = 1'b1;
              pc_w    = zero ? PC_BRANCH : PC_HOLD;
              retire  = 1'b1;
              state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
          endcase
        end
      end

      S_MEM: begin
        if (op_q == OP_SW) begin
          mem_wr = 1'b1;
        end else begin
          mem_rd = 1'b1;
        end
        if (wd_expired) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end else if (mem_ready) begin
          if (op_q == OP_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        if (op_q == OP_LW) begin
          rw      = RW_MEM;
          reg_src = 1'b1;
        end else begin
          rw = RW_ULA;
        end
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      S_HALT:  state_d = S_HALT;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    cnt_d = retire ? (cnt_q + CNT_W'(1)) : cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Everything reads zero while reset is held, including the FETCH strobes.
  always_comb begin
    PCWrite     = '0;
    RegWrite    = '0;
    UlaOp       = '0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    UlaSrc      = 1'b0;
    RegSrc      = 1'b0;
    Jump        = 1'b0;
    beq         = 1'b0;
    halted      = 1'b0;
    illegal     = 1'b0;
    timeout     = 1'b0;
    instr_count = '0;
    state       = '0;
    if (reset) begin
      PCWrite     = pc_w;
      RegWrite    = rw;
      UlaOp       = ula_op;
      IRWrite     = ir_w;
      MemRead     = mem_rd;
      MemWrite    = mem_wr;
      UlaSrc      = ula_src;
      RegSrc      = reg_src;
      Jump        = jump_s;
      beq         = beq_s;
      halted      = (state_q == S_HALT);
      illegal     = (state_q == S_TRAP) && illegal_q;
      timeout     = (state_q == S_TRAP) && timeout_q;
      instr_count = cnt_q;
      state       = state_q;
    end
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Randomized self-checking bench: per-instruction cycle schedules built from
// the instruction timing rules, compared against the DUT every cycle.
module tb_controle_multiciclo;

  localparam int unsigned TMO = 4;
  localparam int B_IRW = 6, B_MRD = 5, B_MWR = 4, B_USRC = 3, B_RSRC = 2, B_JMP = 1, B_BEQ = 0;

  logic       clk = 1'b1;
  logic       reset;
  logic [3:0] opCode;
  logic       mem_ready, zero;
  logic [1:0] PCWrite, RegWrite, UlaOp;
  logic       IRWrite, MemRead, MemWrite, UlaSrc, RegSrc, Jump, beq;
  logic       halted, illegal, timeout;
  logic [1:0] instr_count;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [3:0] op;
    logic       rdy;
    logic       z;
    logic [2:0] st;
    logic [1:0] pcw, rw, ula;
    logic [6:0] strb;
    logic       hlt, ill, tmo;
    logic [1:0] cnt;
  } cyc_t;

  typedef struct {
    logic [2:0] st;
    logic [1:0] pcw, rw;
    logic [6:0] strb;
    logic       hlt, ill, tmo;
    logic [1:0] cnt;
  } obs_t;

  cyc_t plan[$];
  cyc_t chkq[$];
  obs_t obs[$];
  cyc_t ce;
  obs_t oo;

  int unsigned m_cnt = 0;
  bit          dead  = 0;

  controle_multiciclo #(
    .OPCODE_W   (4),
    .MEM_TIMEOUT(TMO),
    .CNT_W      (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .opCode     (opCode),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .UlaOp      (UlaOp),
    .IRWrite    (IRWrite),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .UlaSrc     (UlaSrc),
    .RegSrc     (RegSrc),
    .Jump       (Jump),
    .beq        (beq),
    .halted     (halted),
    .illegal    (illegal),
    .timeout    (timeout),
    .instr_count(instr_count),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic cyc_t blank(input logic [2:0] st);
    cyc_t c;
    c.rst  = 1'b1;
    c.op   = 4'($urandom);
    c.rdy  = 1'($urandom);
    c.z    = 1'($urandom);
    c.st   = st;
    c.pcw  = 2'b00;
    c.rw   = 2'b00;
    c.ula  = 2'b00;
    c.strb = 7'b0;
    c.hlt  = 1'b0;
    c.ill  = 1'b0;
    c.tmo  = 1'b0;
    c.cnt  = 2'(m_cnt);
    return c;
  endfunction

  task automatic add_reset(input int unsigned n);
    cyc_t c;
    m_cnt = 0;
    dead  = 0;
    for (int unsigned i = 0; i < n; i++) begin
      c     = blank(3'd0);
      c.rst = 1'b0;
      plan.push_back(c);
    end
  endtask

  task automatic add_term(input logic [2:0] st, input logic ill, input logic tmo);
    cyc_t c;
    dead = 1;
    for (int unsigned i = 0; i < 3; i++) begin
      c     = blank(st);
      c.hlt = (st == 3'd5);
      c.ill = ill;
      c.tmo = tmo;
      plan.push_back(c);
    end
  endtask

  // Waiting cycles of FETCH or MEM; TMO or more waits end in a timeout trap.
  task automatic wait_phase(input logic [2:0] st, input int unsigned w, input logic [6:0] strb, output bit ok);
    cyc_t c;
    for (int unsigned i = 0; i < w && i < TMO; i++) begin
      c      = blank(st);
      c.rdy  = 1'b0;
      c.strb = strb;
      plan.push_back(c);
    end
    ok = 1;
    if (w >= TMO) begin
      c      = blank(st);
      c.rdy  = 1'b1;
      c.strb = strb;
      plan.push_back(c);
      add_term(3'd6, 1'b0, 1'b1);
      ok = 0;
    end
  endtask

  task automatic add_instr(input int unsigned op, input int unsigned wf, input int unsigned wm, input logic z);
    cyc_t       c;
    bit         ok;
    logic [6:0] mstrb;
    wait_phase(3'd0, wf, 7'b0100000, ok);
    if (!ok) return;
    c = blank(3'd0);
    c.rdy = 1'b1;
    c.strb[B_MRD] = 1'b1;
    c.strb[B_IRW] = 1'b1;
    c.pcw = 2'b01;
    plan.push_back(c);

    c    = blank(3'd1);
    c.op = 4'(op);
    if (op >= 8) begin
      plan.push_back(c);
      add_term(3'd6, 1'b1, 1'b0);
      return;
    end
    if (op == 7) begin
      plan.push_back(c);
      add_term(3'd5, 1'b0, 1'b0);
      return;
    end
    if (op == 5) begin
      c.strb[B_JMP] = 1'b1;
      c.pcw = 2'b11;
      plan.push_back(c);
      m_cnt++;
      return;
    end
    plan.push_back(c);

    c = blank(3'd2);
    case (op)
      0, 1, 3: c.strb[B_USRC] = 1'b1;
      4:       c.ula = 2'b10;
      6: begin
        c.ula = 2'b01;
        c.strb[B_BEQ] = 1'b1;
        c.z   = z;
        c.pcw = z ? 2'b10 : 2'b00;
      end
      default: ;
    endcase
    plan.push_back(c);
    if (op == 6) begin
      m_cnt++;
      return;
    end

    if (op <= 1) begin
      mstrb = (op == 0) ? 7'b0100000 : 7'b0010000;
      wait_phase(3'd3, wm, mstrb, ok);
      if (!ok) return;
      c      = blank(3'd3);
      c.rdy  = 1'b1;
      c.strb = mstrb;
      plan.push_back(c);
      if (op == 1) begin
        m_cnt++;
        return;
      end
    end

    c = blank(3'd4);
    if (op == 0) begin
      c.rw = 2'b10;
      c.strb[B_RSRC] = 1'b1;
    end else begin
      c.rw = 2'b01;
    end
    plan.push_back(c);
    m_cnt++;
  endtask

  task automatic step();
    cyc_t c;
    c         = plan.pop_front();
    reset     = c.rst;
    opCode    = c.op;
    mem_ready = c.rdy;
    zero      = c.z;
    chkq.push_back(c);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    while (plan.size() != 0) step();
  endtask

  always @(negedge clk) begin
    if (chkq.size() != 0) begin
      ce = chkq.pop_front();
      chk("state", 16'(state), 16'(ce.st));
      chk("PCWrite", 16'(PCWrite), 16'(ce.pcw));
      chk("RegWrite", 16'(RegWrite), 16'(ce.rw));
      chk("UlaOp", 16'(UlaOp), 16'(ce.ula));
      chk("strobes", 16'({IRWrite, MemRead, MemWrite, UlaSrc, RegSrc, Jump, beq}), 16'(ce.strb));
      chk("flags", 16'({halted, illegal, timeout}), 16'({ce.hlt, ce.ill, ce.tmo}));
      chk("instr_count", 16'(instr_count), 16'(ce.cnt));
      oo.st   = state;
      oo.pcw  = PCWrite;
      oo.rw   = RegWrite;
      oo.strb = {IRWrite, MemRead, MemWrite, UlaSrc, RegSrc, Jump, beq};
      oo.hlt  = halted;
      oo.ill  = illegal;
      oo.tmo  = timeout;
      oo.cnt  = instr_count;
      obs.push_back(oo);
    end
  end

  initial begin
    int unsigned roll, op, wf, wm, k2, n;
    reset     = 1'b0;
    opCode    = 4'd0;
    mem_ready = 1'b0;
    zero      = 1'b0;

    add_reset(3);
    drain();

    // add: states 0,1,2,4 then FETCH with count 1
    obs.delete();
    add_instr(2, 0, 0, 1'b0);
    add_instr(2, 0, 0, 1'b0);
    drain();
    chk("t1_st0", 16'(obs[0].st), 16'd0);
    chk("t1_st1", 16'(obs[1].st), 16'd1);
    chk("t1_st2", 16'(obs[2].st), 16'd2);
    chk("t1_st3", 16'(obs[3].st), 16'd4);
    chk("t1_st4", 16'(obs[4].st), 16'd0);
    chk("t1_rw", 16'(obs[3].rw), 16'd1);
    chk("t1_cnt", 16'(obs[4].cnt), 16'd1);

    // lw with three stalled MEM cycles
    obs.delete();
    add_instr(0, 0, 3, 1'b0);
    drain();
    n = 0;
    foreach (obs[i]) if (obs[i].st == 3'd3 && obs[i].strb[B_MRD]) n++;
    chk("t2_memread_cycles", 16'(n), 16'd4);
    chk("t2_wb_st", 16'(obs[7].st), 16'd4);
    chk("t2_wb_rw", 16'(obs[7].rw), 16'd2);
    chk("t2_wb_rsrc", 16'(obs[7].strb[B_RSRC]), 16'd1);

    // beq taken then not taken
    obs.delete();
    add_instr(6, 0, 0, 1'b1);
    add_instr(6, 0, 0, 1'b0);
    drain();
    chk("t3_pcw_taken", 16'(obs[2].pcw), 16'd2);
    chk("t3_beq_taken", 16'(obs[2].strb[B_BEQ]), 16'd1);
    chk("t3_pcw_nt", 16'(obs[5].pcw), 16'd0);
    chk("t3_beq_nt", 16'(obs[5].strb[B_BEQ]), 16'd1);
    chk("t3_back_fetch", 16'(obs[3].st), 16'd0);

    // illegal opcode 1000
    add_reset(2);
    drain();
    obs.delete();
    add_instr(2, 0, 0, 1'b0);
    add_instr(8, 0, 0, 1'b0);
    drain();
    chk("t4_trap", 16'(obs[6].st), 16'd6);
    chk("t4_illegal", 16'(obs[6].ill), 16'd1);
    chk("t4_hold", 16'(obs[8].st), 16'd6);
    chk("t4_cnt", 16'(obs[8].cnt), 16'd1);

    // watchdog expiry in FETCH, then reset clears the trap
    add_reset(2);
    drain();
    obs.delete();
    add_instr(2, TMO, 0, 1'b0);
    drain();
    chk("t5_still_fetch", 16'(obs[4].st), 16'd0);
    chk("t5_trap", 16'(obs[5].st), 16'd6);
    chk("t5_timeout", 16'(obs[5].tmo), 16'd1);
    obs.delete();
    add_reset(2);
    add_instr(2, 0, 0, 1'b0);
    drain();
    chk("t5_rst_flags", 16'({obs[0].hlt, obs[0].ill, obs[0].tmo}), 16'd0);
    chk("t5_fetch_flags", 16'({obs[2].hlt, obs[2].ill, obs[2].tmo}), 16'd0);
    chk("t5_fetch_strb", 16'(obs[2].strb), 16'h60);

    // five adds wrap the 2-bit counter, then halt
    add_reset(2);
    drain();
    obs.delete();
    for (int i = 0; i < 5; i++) add_instr(2, 0, 0, 1'b0);
    add_instr(7, 0, 0, 1'b0);
    drain();
    chk("t6_not_halted_decode", 16'(obs[21].hlt), 16'd0);
    chk("t6_halted", 16'(obs[22].hlt), 16'd1);
    chk("t6_halt_st", 16'(obs[22].st), 16'd5);
    chk("t6_cnt_wrap", 16'(obs[22].cnt), 16'd1);

    add_reset(2);
    drain();
    for (int k = 0; k < 250; k++) begin
      if (dead) add_reset($urandom_range(1, 2));
      roll = $urandom_range(0, 99);
      if (roll < 4)      op = $urandom_range(8, 15);
      else if (roll < 7) op = 7;
      else               op = $urandom_range(0, 6);
      wf = ($urandom_range(0, 19) == 0) ? TMO : $urandom_range(0, 3);
      wm = ($urandom_range(0, 19) == 0) ? TMO : $urandom_range(0, 3);
      add_instr(op, wf, wm, 1'($urandom));
      if ($urandom_range(0, 29) == 0) begin
        k2 = $urandom_range(1, plan.size() - 1);
        repeat (k2) void'(plan.pop_back());
        add_reset(2);
      end
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
